// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 convolution engine.
// CONV_ABS_EN (optional macro) makes conv_mac output the magnitude of negative results.
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRAIN,
    WRITE,
    FIN
  } state_t;

  localparam int unsigned NUM_TAPS = 9;

  localparam logic BORDER_ZERO = 1'b0;
  localparam logic BORDER_REPL = 1'b1;

  // Neighbour offsets per tap, row-major with (-1,-1) first
  localparam logic signed [1:0] TAP_DX [NUM_TAPS] = '{
    -2'sd1, 2'sd0, 2'sd1,
    -2'sd1, 2'sd0, 2'sd1,
    -2'sd1, 2'sd0, 2'sd1
  };
  localparam logic signed [1:0] TAP_DY [NUM_TAPS] = '{
    -2'sd1, -2'sd1, -2'sd1,
     2'sd0,  2'sd0,  2'sd0,
     2'sd1,  2'sd1,  2'sd1
  };

  // Nine signed products never overflow this width
  function automatic int unsigned acc_width(input int unsigned pix_w, input int unsigned coef_w);
    return pix_w + coef_w + 5;
  endfunction

endpackage

// File: rtl/conv_mac.sv
// Accumulate / shift / saturate datapath for one output pixel.
// With CONV_ABS_EN defined, negative shifted results are replaced by their magnitude.
module conv_mac
  import conv_pkg::*;
#(
  parameter int unsigned PIX_W   = 3,
  parameter int unsigned COEF_W  = 5,
  parameter int unsigned SHIFT_W = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_clr,
  input  logic                      i_acc_en,
  input  logic                      i_vld,
  input  logic [PIX_W-1:0]          i_pix,
  input  logic signed [COEF_W-1:0]  i_coef,
  input  logic [SHIFT_W-1:0]        i_shift,
  output logic [PIX_W-1:0]          o_res_c
);

  localparam int unsigned ACC_W  = acc_width(PIX_W, COEF_W);
  localparam int unsigned PROD_W = PIX_W + COEF_W + 1;
  localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((1 << PIX_W) - 1);

  logic signed [PROD_W-1:0] w_a;
  logic signed [PROD_W-1:0] w_b;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  r_acc;
  logic signed [ACC_W-1:0]  w_sum;
  logic signed [ACC_W-1:0]  w_shr;
  logic signed [ACC_W-1:0]  w_mag;

  // Result is taken from the sum including the current tap, so it is ready in DRAIN
  always_comb begin
    w_a    = $signed(PROD_W'({1'b0, i_pix}));
    w_b    = PROD_W'(i_coef);
    w_prod = w_a * w_b;
    w_sum  = r_acc + (i_vld ? ACC_W'(w_prod) : '0);
    w_shr  = w_sum >>> i_shift;
`ifdef CONV_ABS_EN
    w_mag  = w_shr[ACC_W-1] ? -w_shr : w_shr;
`else
    w_mag  = w_shr;
`endif
    if (w_mag[ACC_W-1]) begin
      o_res_c = '0;
    end else if (w_mag > PIX_MAX) begin
      o_res_c = PIX_W'(PIX_MAX);
    end else begin
      o_res_c = PIX_W'(w_mag);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_acc_en) begin
      r_acc <= w_sum;
    end
  end

endmodule

// File: rtl/conv_engine.sv
// Frame-walking 3x3 convolution engine: fetch 9 taps, accumulate, write one pixel per 11 cycles.
// Optional macro CONV_ABS_EN (in conv_mac) takes the magnitude of negative results.
module conv_engine
  import conv_pkg::*;
#(
  parameter int unsigned IMG_W   = 160,
  parameter int unsigned IMG_H   = 120,
  parameter int unsigned PIX_W   = 3,
  parameter int unsigned COEF_W  = 5,
  parameter int unsigned SHIFT_W = 3,
  parameter int unsigned X_W     = $clog2(IMG_W),
  parameter int unsigned Y_W     = $clog2(IMG_H)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      border_mode,
  input  logic [SHIFT_W-1:0]        shift,
  output logic                      busy,
  output logic                      done,
  output logic [X_W-1:0]            src_x,
  output logic [Y_W-1:0]            src_y,
  input  logic [PIX_W-1:0]          src_din,
  output logic [3:0]                ker_addr,
  input  logic signed [COEF_W-1:0]  ker_din,
  output logic                      we,
  output logic [X_W-1:0]            dst_x,
  output logic [Y_W-1:0]            dst_y,
  output logic [PIX_W-1:0]          dst_dout
);

  localparam int unsigned CX_W = X_W + 2;
  localparam int unsigned CY_W = Y_W + 2;
  localparam logic [3:0]  LAST_TAP = 4'(NUM_TAPS - 1);

  state_t                 r_state;
  state_t                 w_state_nx;
  logic [3:0]             r_tap;
  logic [3:0]             w_tap_nx;
  logic [X_W-1:0]         r_x;
  logic [X_W-1:0]         w_x_nx;
  logic [Y_W-1:0]         r_y;
  logic [Y_W-1:0]         w_y_nx;
  logic                   r_border;
  logic [SHIFT_W-1:0]     r_shift;
  logic                   r_vld;
  logic                   r_vld_d;
  logic                   w_issue;
  logic                   w_clr;
  logic                   w_acc_en;
  logic                   w_cap;
  logic                   w_last;
  logic                   w_tap_en;
  logic signed [CX_W-1:0] w_cx;
  logic signed [CY_W-1:0] w_cy;
  logic [X_W-1:0]         w_sx;
  logic [Y_W-1:0]         w_sy;
  logic                   w_in_rng;
  logic [PIX_W-1:0]       w_res_c;

  // Next-state and control
  always_comb begin
    w_state_nx = r_state;
    w_tap_nx   = r_tap;
    w_x_nx     = r_x;
    w_y_nx     = r_y;
    w_issue    = 1'b0;
    w_clr      = 1'b0;
    w_acc_en   = 1'b0;
    w_cap      = 1'b0;
    w_last     = (r_x == X_W'(IMG_W - 1)) && (r_y == Y_W'(IMG_H - 1));
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nx = FETCH;
          w_tap_nx   = '0;
          w_x_nx     = '0;
          w_y_nx     = '0;
          w_issue    = 1'b1;
        end
      end
      FETCH: begin
        w_clr    = (r_tap == '0);
        w_acc_en = (r_tap != '0);
        if (r_tap == LAST_TAP) begin
          w_state_nx = DRAIN;
        end else begin
          w_tap_nx = r_tap + 4'd1;
          w_issue  = 1'b1;
        end
      end
      DRAIN: begin
        w_acc_en   = 1'b1;
        w_cap      = 1'b1;
        w_state_nx = WRITE;
      end
      WRITE: begin
        if (w_last) begin
          w_state_nx = FIN;
        end else begin
          w_state_nx = FETCH;
          w_tap_nx   = '0;
          w_issue    = 1'b1;
          if (r_x == X_W'(IMG_W - 1)) begin
            w_x_nx = '0;
            w_y_nx = r_y + Y_W'(1);
          end else begin
            w_x_nx = r_x + X_W'(1);
          end
        end
      end
      FIN:     w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  // Clamp the neighbour coordinate; remember whether it was really inside the frame
  always_comb begin
    w_cx     = $signed({2'b00, w_x_nx}) + CX_W'(TAP_DX[w_tap_nx]);
    w_cy     = $signed({2'b00, w_y_nx}) + CY_W'(TAP_DY[w_tap_nx]);
    w_sx     = X_W'(w_cx);
    w_sy     = Y_W'(w_cy);
    w_in_rng = 1'b1;
    if (w_cx[CX_W-1]) begin
      w_sx     = '0;
      w_in_rng = 1'b0;
    end else if (w_cx > $signed(CX_W'(IMG_W - 1))) begin
      w_sx     = X_W'(IMG_W - 1);
      w_in_rng = 1'b0;
    end
    if (w_cy[CY_W-1]) begin
      w_sy     = '0;
      w_in_rng = 1'b0;
    end else if (w_cy > $signed(CY_W'(IMG_H - 1))) begin
      w_sy     = Y_W'(IMG_H - 1);
      w_in_rng = 1'b0;
    end
  end

  assign w_tap_en = r_vld_d | (r_border == BORDER_REPL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_tap    <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_border <= BORDER_ZERO;
      r_shift  <= '0;
      r_vld    <= 1'b0;
      r_vld_d  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      we       <= 1'b0;
      src_x    <= '0;
      src_y    <= '0;
      ker_addr <= '0;
      dst_x    <= '0;
      dst_y    <= '0;
      dst_dout <= '0;
    end else begin
      r_state <= w_state_nx;
      r_tap   <= w_tap_nx;
      r_x     <= w_x_nx;
      r_y     <= w_y_nx;
      r_vld_d <= r_vld;
      busy    <= (w_state_nx == FETCH) || (w_state_nx == DRAIN) || (w_state_nx == WRITE);
      done    <= (w_state_nx == FIN);
      we      <= (w_state_nx == WRITE);
      if ((r_state == IDLE) && start) begin
        r_border <= border_mode;
        r_shift  <= shift;
      end
      if (w_issue) begin
        src_x    <= w_sx;
        src_y    <= w_sy;
        ker_addr <= w_tap_nx;
        r_vld    <= w_in_rng;
      end
      if (w_cap) begin
        dst_x    <= r_x;
        dst_y    <= r_y;
        dst_dout <= w_res_c;
      end
    end
  end

  conv_mac #(
    .PIX_W   (PIX_W),
    .COEF_W  (COEF_W),
    .SHIFT_W (SHIFT_W)
  ) u_mac (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_clr),
    .i_acc_en (w_acc_en),
    .i_vld    (w_tap_en),
    .i_pix    (src_din),
    .i_coef   (ker_din),
    .i_shift  (r_shift),
    .o_res_c  (w_res_c)
  );

endmodule

// File: tb/tb_conv_engine.sv
// Directed bench for conv_engine on a 4x3 frame with 1-cycle ROM models.
module tb_conv_engine;

  localparam int IW   = 4;
  localparam int IH   = 3;
  localparam int NPIX = IW * IH;

  typedef struct packed {
    logic [8:0][4:0]  ker;
    logic [11:0][2:0] img;
    logic             border;
    logic [2:0]       shift;
    logic [11:0][2:0] expv;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       border_mode;
  logic [2:0] shift;
  logic       busy;
  logic       done;
  logic [1:0] src_x;
  logic [1:0] src_y;
  logic [2:0] src_din;
  logic [3:0] ker_addr;
  logic [4:0] ker_din;
  logic       we;
  logic [1:0] dst_x;
  logic [1:0] dst_y;
  logic [2:0] dst_dout;

  logic [11:0][2:0] cur_img;
  logic [8:0][4:0]  cur_ker;
  logic [2:0]       out_pix [NPIX];
  int               wr_cnt   = 0;
  int               done_cnt = 0;
  int               cyc      = 0;
  int               n_vec;
  int               n_err;
  vec_t             vecs [6];

  conv_engine #(
    .IMG_W   (IW),
    .IMG_H   (IH),
    .PIX_W   (3),
    .COEF_W  (5),
    .SHIFT_W (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .border_mode (border_mode),
    .shift       (shift),
    .busy        (busy),
    .done        (done),
    .src_x       (src_x),
    .src_y       (src_y),
    .src_din     (src_din),
    .ker_addr    (ker_addr),
    .ker_din     (ker_din),
    .we          (we),
    .dst_x       (dst_x),
    .dst_y       (dst_y),
    .dst_dout    (dst_dout)
  );

  always #5 clk = ~clk;

  // Source image and kernel ROMs, one cycle read latency
  always @(posedge clk) begin : rom
    int idx;
    cyc = cyc + 1;
    idx = int'(src_y) * IW + int'(src_x);
    if (idx < NPIX) src_din <= cur_img[idx];
    else            src_din <= '0;
    if (ker_addr < 4'd9) ker_din <= cur_ker[ker_addr];
    else                 ker_din <= '0;
  end

  // Output frame RAM model
  always @(negedge clk) begin : cap
    int idx;
    if (we) begin
      idx = int'(dst_y) * IW + int'(dst_x);
      if (idx < NPIX) out_pix[idx] = dst_dout;
      wr_cnt = wr_cnt + 1;
    end
    if (done) done_cnt = done_cnt + 1;
  end

  function automatic logic [8:0][4:0] mk_ker(input int c, input int nb);
    logic [8:0][4:0] k;
    for (int i = 0; i < 9; i++) k[i] = (i == 4) ? 5'(c) : 5'(nb);
    return k;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_vec = n_vec + 1;
    if (act != exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Run one frame; optionally re-pulse start while busy at loop step restart_at
  task automatic run_frame(input int id, input vec_t v, input int restart_at);
    int wc0;
    int dc0;
    int t0;
    bit got;
    cur_img     = v.img;
    cur_ker     = v.ker;
    border_mode = v.border;
    shift       = v.shift;
    start       = 1'b1;
    @(negedge clk);
    start       = 1'b0;
    border_mode = ~v.border;
    shift       = ~v.shift;
    wc0 = wr_cnt;
    dc0 = done_cnt;
    t0  = cyc;
    chk($sformatf("v%0d_busy_rise", id), busy, 1);
    got = 1'b0;
    for (int k = 1; k < 400 && !got; k++) begin
      if (k == restart_at) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (done) got = 1'b1;
    end
    chk($sformatf("v%0d_done_seen", id), int'(got), 1);
    chk($sformatf("v%0d_done_latency", id), cyc - t0, 11 * NPIX);
    @(negedge clk);
    chk($sformatf("v%0d_busy_after", id), busy, 0);
    chk($sformatf("v%0d_done_width", id), done, 0);
    chk($sformatf("v%0d_writes", id), wr_cnt - wc0, NPIX);
    chk($sformatf("v%0d_done_pulses", id), done_cnt - dc0, 1);
    for (int i = 0; i < NPIX; i++)
      chk($sformatf("v%0d_pix%0d", id, i), out_pix[i], v.expv[i]);
  endtask

  initial begin
    int  wc;
    bit  got;
    n_vec       = 0;
    n_err       = 0;
    rst         = 1'b1;
    start       = 1'b0;
    border_mode = 1'b0;
    shift       = '0;
    cur_img     = '0;
    cur_ker     = '0;
    for (int i = 0; i < NPIX; i++) out_pix[i] = '0;

    // identity, ramp image
    vecs[0] = '{ker: mk_ker(1, 0),  img: 36'o321076543210, border: 1'b0, shift: 3'd0,
                expv: 36'o321076543210};
    // all-ones, constant 7, zero-pad, >>3
    vecs[1] = '{ker: mk_ker(1, 1),  img: 36'o777777777777, border: 1'b0, shift: 3'd3,
                expv: 36'o355357753553};
    // all-ones, constant 7, replicate, >>3
    vecs[2] = '{ker: mk_ker(1, 1),  img: 36'o777777777777, border: 1'b1, shift: 3'd3,
                expv: 36'o777777777777};
    // Laplacian, single 7 at (1,1)
    vecs[3] = '{ker: mk_ker(-8, 1), img: 36'o000000700000, border: 1'b0, shift: 3'd0,
                expv: 36'o077707070777};
    // centre -1, constant 3, >>1 : -3>>>1 = -2 (floor)
    vecs[4] = '{ker: mk_ker(-1, 0), img: 36'o333333333333, border: 1'b1, shift: 3'd1,
                expv: 36'o000000000000};
    // centre 15, ramp, >>2 : high-side saturation
    vecs[5] = '{ker: mk_ker(15, 0), img: 36'o321076543210, border: 1'b0, shift: 3'd2,
                expv: 36'o773077777730};
`ifdef CONV_ABS_EN
    vecs[3].expv = 36'o077707770777;
    vecs[4].expv = 36'o222222222222;
`endif

    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_we", we, 0);
    chk("rst_dout", dst_dout, 0);
    chk("rst_src_x", src_x, 0);
    chk("rst_ker_addr", ker_addr, 0);
    rst = 1'b0;
    @(negedge clk);

    // Asynchronous reset landing on a WRITE cycle mid-frame
    cur_img     = vecs[1].img;
    cur_ker     = vecs[1].ker;
    border_mode = 1'b0;
    shift       = 3'd3;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got   = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      if (k >= 40 && we) got = 1'b1;
    end
    chk("midrst_reached_write", int'(got), 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_we", we, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    wc = wr_cnt;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("midrst_no_writes", wr_cnt - wc, 0);
    chk("midrst_idle", busy, 0);

    for (int v = 0; v < 6; v++) run_frame(v, vecs[v], 0);

    // start re-pulsed while busy must be ignored
    run_frame(6, vecs[0], 20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/conv_engine.md
Name: conv_engine

Overview:
- Parametrised 3x3 convolution engine that replaces the fixed-size convolution datapath in the processor.
- On a start pulse it walks every pixel of an IMG_W x IMG_H source image in raster order.
- For each pixel it fetches the 9 neighbourhood pixels and the 9 kernel coefficients, accumulates, normalises and saturates the result, then writes it to the output frame RAM.
- Adds runtime border mode, runtime normalisation shift and a start/busy/done handshake.

Parameters:
- IMG_W, 160, image width in pixels.
- IMG_H, 120, image height in pixels.
- PIX_W, 3, pixel width (unsigned).
- COEF_W, 5, kernel coefficient width (signed two's complement).
- SHIFT_W, 3, width of the normalisation shift input.
- X_W, $clog2(IMG_W), x address width (derived).
- Y_W, $clog2(IMG_H), y address width (derived).

Ports:
- clk  in  1  processor clock.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  single-cycle request to convolve one frame.
- border_mode  in  1  0 = zero-pad, 1 = replicate edge; sampled at start.
- shift  in  SHIFT_W  arithmetic right-shift applied to the sum; sampled at start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last write.
- src_x  out  X_W  source ROM x address.
- src_y  out  Y_W  source ROM y address.
- src_din  in  PIX_W  source pixel; 1-cycle synchronous read latency.
- ker_addr  out  4  kernel tap index 0..8, row-major, (-1,-1) first.
- ker_din  in  COEF_W  kernel coefficient; 1-cycle latency.
- we  out  1  output RAM write enable.
- dst_x  out  X_W  output pixel x.
- dst_y  out  Y_W  output pixel y.
- dst_dout  out  PIX_W  convolved pixel.

Behaviour:
- Reset: all outputs are 0 and the FSM is in IDLE. The reset takes effect asynchronously even mid-frame, so no further writes occur.
- FSM states: IDLE, FETCH, DRAIN, WRITE, FIN.
  - IDLE: start=1 latches border_mode and shift, sets pixel (0,0) and tap 0, and goes to FETCH. busy rises the next cycle.
  - FETCH (9 cycles): each cycle issues src_x/src_y/ker_addr for tap t = 0..8. Data for tap t-1 is accumulated in the same cycle. After t=8 go to DRAIN.
  - DRAIN (1 cycle): accumulate tap 8 and compute the result.
  - WRITE (1 cycle): we=1 with dst_x/dst_y/dst_dout valid. Then advance x, wrapping to 0 and incrementing y. After (IMG_W-1, IMG_H-1) go to FIN, otherwise go to FETCH.
  - FIN: done=1 and busy=0 for one cycle, then IDLE.
- Throughput: exactly 11 cycles per pixel. The frame takes 11*IMG_W*IMG_H cycles from the first FETCH to the last WRITE.
- start while busy or in FIN is ignored. Inputs are not re-sampled until IDLE.
- Neighbour coordinate = (x+dx, y+dy), dx and dy in {-1, 0, +1}.
  - Out of range, replicate mode: the coordinate is clamped to [0, IMG_W-1] / [0, IMG_H-1].
  - Out of range, zero-pad mode: the address is clamped identically, but a per-tap valid flag, delayed 1 cycle with the data, forces that tap's contribution to 0.
- Arithmetic:
  - Accumulator is signed, ACC_W = PIX_W+COEF_W+5 bits, with no overflow possible.
  - Product = signed(src_din zero-extended) * signed(ker_din).
  - Result = acc >>> shift (arithmetic, floor).
  - Saturate to [0, 2^PIX_W-1].
- The accumulator clears at the start of each pixel's FETCH.
- we is never asserted outside WRITE.

Optional Feature:
- Macro: CONV_ABS_EN.
- Defined: a negative shifted result is replaced by its magnitude before saturation, for edge-detection kernels.
- Undefined: negative results saturate to 0.
- Timing and latency are identical in both builds.

Decomposition:
- Package conv_pkg holds:
  - state enum;
  - BORDER_ZERO=0 / BORDER_REPL=1;
  - TAP_DX/TAP_DY offset tables indexed by tap;
  - NUM_TAPS=9;
  - ACC_W derivation function.
- Sub-module conv_mac: accumulate, clear, shift, abs (under CONV_ABS_EN) and saturate. It is a purely datapath block driven by the FSM.

Test Plan (IMG_W=4, IMG_H=3, behavioural 1-cycle ROM models):
- Identity kernel (centre 1, others 0), shift=0, ramp image -> output equals input at all 12 pixels; done pulses 132 cycles after the first FETCH; busy low afterwards.
- All-ones kernel, shift=3, constant-7 image, zero-pad:
  - interior (1,1) = 63>>3 = 7;
  - corner (0,0) = 28>>3 = 3;
  - edge (1,0) = 42>>3 = 5.
- Same stimulus with replicate mode -> every pixel = 7.
- Laplacian (centre -8, neighbours 1), shift=0, single pixel of 7 at (1,1) in a zero image:
  - without CONV_ABS_EN, (1,1) = 0 (saturate);
  - with CONV_ABS_EN, (1,1) = 7 (|-56| saturates); neighbours = 7.
- Assert rst at cycle 50 mid-frame -> we/busy/done are 0 the same cycle with no further writes; a subsequent start runs a full frame correctly.
- Pulse start again at cycle 20 while busy -> ignored; exactly 12 writes and one done pulse.
